// File: rtl/key_repeat_fifo_pkg.sv
// ============================================================================
// Module  : key_repeat_fifo_pkg
// Brief   : Shared types and helpers for the typematic keyboard buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package key_repeat_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } kr_state_t;

    localparam int C_NULL_KEY = 0;

    // Counter must hold values up to max(delay, rate) - 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage : key_repeat_fifo_pkg

`default_nettype wire

// File: rtl/key_repeat_fifo_if.sv
// ============================================================================
// Module  : key_repeat_fifo_if
// Brief   : Key input / CPU pop port bundle for the keyboard buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface key_repeat_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 6
);
    logic [DATA_W-1:0]   key_code;
    logic                rd_en;
    logic                flush;
    logic                clr_ovf;
    logic [DATA_W-1:0]   cpu_data;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;

    modport master (
        output key_code, rd_en, flush, clr_ovf,
        input  cpu_data, empty, full, count, overflow
    );

    modport slave (
        input  key_code, rd_en, flush, clr_ovf,
        output cpu_data, empty, full, count, overflow
    );
endinterface : key_repeat_fifo_if

`default_nettype wire

// File: rtl/key_repeat_fifo_core.sv
// ============================================================================
// Module  : key_fifo_core
// Brief   : Single-clock FIFO with flush, registered occupancy and head data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_fifo_core #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_push,
    input  wire logic [DATA_W-1:0]   i_push_data,
    input  wire logic                i_pop,
    input  wire logic                i_flush,
    output logic      [DATA_W-1:0]   o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic      [DEPTH_LOG2:0] o_count
);

    localparam int                  c_DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL  = (DEPTH_LOG2 + 1)'(c_DEPTH);

    logic [DATA_W-1:0]     r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_head;
    logic [DEPTH_LOG2-1:0] r_tail;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic [DATA_W-1:0]     r_data;

    logic                  w_do_pop;
    logic                  w_do_push;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    // Flush wins over everything; a full FIFO still accepts a push when a pop frees a slot.
    assign w_do_pop  = i_pop & ~r_empty & ~i_flush;
    assign w_do_push = i_push & ~i_flush & (~r_full | w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + (DEPTH_LOG2 + 1)'(w_do_push) - (DEPTH_LOG2 + 1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_tail] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_flush) begin
                r_head <= r_tail;
            end else if (w_do_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_do_push) begin
                r_tail <= r_tail + 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_FULL);
            // Pop and peek both present the pre-edge head; empty or flush shows zero.
            r_data  <= (i_flush || r_empty) ? '0 : r_mem[r_head];
        end
    end

    assign o_data  = r_data;
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_count = r_count;

endmodule : key_fifo_core

`default_nettype wire

// File: rtl/key_repeat_fifo.sv
// ============================================================================
// Module  : key_repeat_fifo
// Brief   : Typematic key-event generator feeding a CPU-readable event FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_repeat_fifo
    import key_repeat_fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 6,
    parameter int DELAY_CYC  = 300000,
    parameter int RATE_CYC   = 30000,
    parameter bit REPEAT_EN  = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    key_repeat_fifo_if.slave bus
);

    localparam int                c_CNT_W     = cnt_width(DELAY_CYC, RATE_CYC);
    localparam logic [c_CNT_W-1:0] c_DELAY_END = c_CNT_W'(DELAY_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_RATE_END  = c_CNT_W'(RATE_CYC - 1);
    localparam logic [DATA_W-1:0]  c_NULL      = DATA_W'(C_NULL_KEY);

    kr_state_t           r_state;
    kr_state_t           w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0]   r_prev_code;
    logic [DATA_W-1:0]   w_prev_nxt;
    logic                w_push;
    logic                r_overflow;
    logic                w_drop;

    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [DEPTH_LOG2:0] w_fifo_count;
    logic [DATA_W-1:0]   w_fifo_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_prev_code <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_prev_code <= w_prev_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_prev_nxt  = r_prev_code;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.key_code != c_NULL) begin
                    w_push      = 1'b1;
                    w_prev_nxt  = bus.key_code;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (bus.key_code == c_NULL) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (bus.key_code != r_prev_code) begin
                    // Rollover to a new key restarts the typematic delay immediately.
                    w_push      = 1'b1;
                    w_prev_nxt  = bus.key_code;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DELAY;
                end else if (r_state == ST_DELAY) begin
                    if (r_cnt == c_DELAY_END) begin
                        if (REPEAT_EN) begin
                            w_push      = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_REPEAT;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    if (r_cnt == c_RATE_END) begin
                        w_push    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    key_fifo_core #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (bus.key_code),
        .i_pop       (bus.rd_en),
        .i_flush     (bus.flush),
        .o_data      (w_fifo_data),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_count     (w_fifo_count)
    );

    // A full FIFO only loses the event when no pop frees a slot; flushed pushes are not losses.
    assign w_drop = w_push & w_fifo_full & ~bus.rd_en & ~bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.cpu_data = w_fifo_data;
    assign bus.empty    = w_fifo_empty;
    assign bus.full     = w_fifo_full;
    assign bus.count    = w_fifo_count;
    assign bus.overflow = r_overflow;

endmodule : key_repeat_fifo

`default_nettype wire

// File: tb/tb_key_repeat_fifo.sv
// ============================================================================
// Module  : tb_key_repeat_fifo
// Brief   : Directed self-checking bench for key_repeat_fifo (repeat on/off).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_repeat_fifo;

    localparam int DATA_W     = 8;
    localparam int DEPTH_LOG2 = 2;
    localparam int DELAY_CYC  = 8;
    localparam int RATE_CYC   = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    key_repeat_fifo_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus_rp ();
    key_repeat_fifo_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus_nr ();

    key_repeat_fifo #(
        .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2),
        .DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC), .REPEAT_EN(1'b1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_rp.slave)
    );

    key_repeat_fifo #(
        .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2),
        .DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC), .REPEAT_EN(1'b0)
    ) u_dut_nr (
        .clk (clk),
        .rst (rst),
        .bus (bus_nr.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus_rp.key_code = '0; bus_rp.rd_en = 1'b0; bus_rp.flush = 1'b0; bus_rp.clr_ovf = 1'b0;
        bus_nr.key_code = '0; bus_nr.rd_en = 1'b0; bus_nr.flush = 1'b0; bus_nr.clr_ovf = 1'b0;
        tick(2);
        rst = 1'b0;

        check("rst_count",    32'(bus_rp.count),    32'd0);
        check("rst_empty",    32'(bus_rp.empty),    32'd1);
        check("rst_full",     32'(bus_rp.full),     32'd0);
        check("rst_overflow", 32'(bus_rp.overflow), 32'd0);
        check("rst_cpu_data", 32'(bus_rp.cpu_data), 32'd0);

        // Single short press
        bus_rp.key_code = 8'h41;
        tick();
        bus_rp.key_code = 8'h00;
        check("press_count", 32'(bus_rp.count), 32'd1);
        check("press_empty", 32'(bus_rp.empty), 32'd0);
        check("press_data_lag", 32'(bus_rp.cpu_data), 32'd0);
        tick();
        check("peek_data", 32'(bus_rp.cpu_data), 32'h41);
        bus_rp.rd_en = 1'b1;
        tick();
        bus_rp.rd_en = 1'b0;
        check("pop_data",  32'(bus_rp.cpu_data), 32'h41);
        check("pop_empty", 32'(bus_rp.empty),    32'd1);
        check("pop_count", 32'(bus_rp.count),    32'd0);
        tick();
        check("idle_data", 32'(bus_rp.cpu_data), 32'd0);

        // Held key: pushes at edges 0, 8, 11, 14; edge 17 overflows
        bus_rp.key_code = 8'h41;
        for (int i = 0; i <= 17; i++) begin
            tick();
            if (i == 7)  check("hold_cnt_e7",  32'(bus_rp.count), 32'd1);
            if (i == 8)  check("hold_cnt_e8",  32'(bus_rp.count), 32'd2);
            if (i == 10) check("hold_cnt_e10", 32'(bus_rp.count), 32'd2);
            if (i == 11) check("hold_cnt_e11", 32'(bus_rp.count), 32'd3);
            if (i == 14) begin
                check("hold_cnt_e14",  32'(bus_rp.count), 32'd4);
                check("hold_full_e14", 32'(bus_rp.full),  32'd1);
            end
            if (i == 16) check("hold_ovf_e16", 32'(bus_rp.overflow), 32'd0);
        end
        check("hold_ovf_e17", 32'(bus_rp.overflow), 32'd1);
        check("hold_cnt_e17", 32'(bus_rp.count),    32'd4);
        bus_rp.key_code = 8'h00;
        tick();

        bus_rp.clr_ovf = 1'b1;
        tick();
        bus_rp.clr_ovf = 1'b0;
        check("clr_ovf", 32'(bus_rp.overflow), 32'd0);

        // Full FIFO: push and pop in the same cycle
        bus_rp.key_code = 8'h55;
        bus_rp.rd_en    = 1'b1;
        tick();
        bus_rp.key_code = 8'h00;
        bus_rp.rd_en    = 1'b0;
        check("fullpp_count", 32'(bus_rp.count),    32'd4);
        check("fullpp_ovf",   32'(bus_rp.overflow), 32'd0);
        check("fullpp_data",  32'(bus_rp.cpu_data), 32'h41);
        bus_rp.rd_en = 1'b1;
        tick(4);
        bus_rp.rd_en = 1'b0;
        check("drain_last",  32'(bus_rp.cpu_data), 32'h55);
        check("drain_empty", 32'(bus_rp.empty),    32'd1);

        // Rollover 0x41 -> 0x42 with no release
        bus_rp.key_code = 8'h41;
        tick(3);
        bus_rp.key_code = 8'h42;
        tick();
        bus_rp.key_code = 8'h00;
        tick();
        check("roll_count", 32'(bus_rp.count), 32'd2);
        bus_rp.rd_en = 1'b1;
        tick();
        check("roll_first", 32'(bus_rp.cpu_data), 32'h41);
        tick();
        bus_rp.rd_en = 1'b0;
        check("roll_second", 32'(bus_rp.cpu_data), 32'h42);
        check("roll_empty",  32'(bus_rp.empty),    32'd1);

        // Flush beats same-cycle pop and push
        bus_rp.key_code = 8'h31; tick();
        bus_rp.key_code = 8'h32; tick();
        bus_rp.key_code = 8'h33; tick();
        bus_rp.key_code = 8'h00; tick();
        check("q3_count", 32'(bus_rp.count), 32'd3);
        bus_rp.flush    = 1'b1;
        bus_rp.rd_en    = 1'b1;
        bus_rp.key_code = 8'h34;
        tick();
        bus_rp.flush = 1'b0;
        bus_rp.rd_en = 1'b0;
        check("flush_count", 32'(bus_rp.count),    32'd0);
        check("flush_data",  32'(bus_rp.cpu_data), 32'd0);
        check("flush_ovf",   32'(bus_rp.overflow), 32'd0);
        check("flush_empty", 32'(bus_rp.empty),    32'd1);

        // Held 0x34 keeps repeating after the flush (flush edge was hold edge 0)
        tick(8);
        check("post_flush_rep", 32'(bus_rp.count),    32'd1);
        check("post_flush_dat", 32'(bus_rp.cpu_data), 32'd0);
        tick(11);
        check("refill_count", 32'(bus_rp.count),    32'd4);
        check("refill_ovf",   32'(bus_rp.overflow), 32'd0);
        bus_rp.clr_ovf = 1'b1;
        tick();
        bus_rp.clr_ovf  = 1'b0;
        bus_rp.key_code = 8'h00;
        check("clr_vs_ovf", 32'(bus_rp.overflow), 32'd1);
        bus_rp.clr_ovf = 1'b1;
        tick();
        bus_rp.clr_ovf = 1'b0;
        check("clr_after", 32'(bus_rp.overflow), 32'd0);

        // Repeat disabled: one event per press; reset mid-hold re-pushes
        bus_nr.key_code = 8'h0D;
        tick(40);
        check("norep_count", 32'(bus_nr.count),    32'd1);
        check("norep_ovf",   32'(bus_nr.overflow), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_hold_count", 32'(bus_nr.count),    32'd0);
        check("rst_hold_data",  32'(bus_nr.cpu_data), 32'd0);
        check("rst_main_count", 32'(bus_rp.count),    32'd0);
        tick();
        check("repush_count", 32'(bus_nr.count), 32'd1);
        bus_nr.key_code = 8'h00;
        tick();
        check("repush_data", 32'(bus_nr.cpu_data), 32'h0D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_key_repeat_fifo

`default_nettype wire
